// File: rtl/seg_pkg.sv
// Shared constants, state type and sizing helper for the multi-channel
// seven-segment driver. All segment codes are active-low {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } segState_t;

  // Nibbles needed to hold any BIN_W-bit value in BCD.
  function automatic int bcdDigits(input int binW);
    return (binW * 3) / 10 + 1;
  endfunction

endpackage

// File: rtl/seg_digit_encoder.sv
// Combinational BCD digit to active-low seven-segment code.
// Codes 10..15 render as blank.
module seg_digit_encoder
  import seg_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_channel_seg_driver.sv
// Multi-channel binary to seven-segment driver: optional count-down reversal,
// serial double-dabble per channel, atomic registered commit of all displays.
//
// state     | meaning
// ST_IDLE   | ready; accept captures and reverses all channel values
// ST_CONV   | one double-dabble step per cycle, channel by channel
// ST_COMMIT | encode staging, write HexOut, pulse UpdDone
module multi_channel_seg_driver
  import seg_pkg::*;
#(
  parameter int                NUM_CH  = 2,
  parameter int                BIN_W   = 8,
  parameter int                DIGITS  = 2,
  parameter logic [BIN_W-1:0]  REV_MAX = BIN_W'(99)
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic [NUM_CH*BIN_W-1:0]    BinIn,
  input  logic                       ModeSel,
  input  logic                       BlankEn,
  input  logic                       InValid,
  output logic                       InReady,
  output logic [NUM_CH*DIGITS*7-1:0] HexOut,
  output logic                       UpdDone
);

  localparam int BCD_DIG = bcdDigits(BIN_W);
  localparam int BCD_W   = BCD_DIG * 4;
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BIT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BIN_W - 1);

  segState_t state, stateNxt;

  logic [BIN_W-1:0] valReg [NUM_CH];
  logic [BCD_W-1:0] staging [NUM_CH];
  logic [BCD_W-1:0] acc, accAdj, accNxt;
  logic [CH_W-1:0]  chIdx;
  logic [BIT_W-1:0] bitIdx;
  logic             blankReg;
  logic             accept, lastStep, doCommit;

  logic [6:0]                  segRaw [NUM_CH*DIGITS];
  logic [NUM_CH-1:0]           ovf;
  logic [NUM_CH*DIGITS*7-1:0]  hexNxt;
  logic                        leadZero;

  function automatic logic [BIN_W-1:0] reverseVal(input logic [BIN_W-1:0] v,
                                                  input logic down);
    if (!down) return v;
    return (v <= REV_MAX) ? (REV_MAX - v) : '0;
  endfunction

  assign lastStep = (bitIdx == LAST_BIT) && (chIdx == LAST_CH);

  always_ff @(posedge Clk) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    InReady  = 1'b0;
    accept   = 1'b0;
    doCommit = 1'b0;
    case (state)
      ST_IDLE: begin
        InReady = 1'b1;
        if (InValid) begin
          accept   = 1'b1;
          stateNxt = ST_CONV;
        end
      end
      ST_CONV: begin
        if (lastStep) stateNxt = ST_COMMIT;
      end
      ST_COMMIT: begin
        doCommit = 1'b1;
        stateNxt = ST_IDLE;
      end
      default: stateNxt = ST_IDLE;
    endcase
  end

  // Add-3 on every nibble >= 5, then shift in the current channel's MSB.
  always_comb begin
    accAdj = acc;
    for (int n = 0; n < BCD_DIG; n++) begin
      if (acc[n*4 +: 4] >= 4'd5) accAdj[n*4 +: 4] = acc[n*4 +: 4] + 4'd3;
    end
    accNxt = {accAdj[BCD_W-2:0], valReg[chIdx][BIN_W-1]};
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      acc      <= '0;
      chIdx    <= '0;
      bitIdx   <= '0;
      blankReg <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        valReg[c]  <= '0;
        staging[c] <= '0;
      end
    end else if (accept) begin
      acc      <= '0;
      chIdx    <= '0;
      bitIdx   <= '0;
      blankReg <= BlankEn;
      for (int c = 0; c < NUM_CH; c++) begin
        valReg[c] <= reverseVal(BinIn[c*BIN_W +: BIN_W], ModeSel);
      end
    end else if (state == ST_CONV) begin
      valReg[chIdx] <= valReg[chIdx] << 1;
      if (bitIdx == LAST_BIT) begin
        staging[chIdx] <= accNxt;
        acc            <= '0;
        bitIdx         <= '0;
        chIdx          <= chIdx + 1'b1;
      end else begin
        acc    <= accNxt;
        bitIdx <= bitIdx + 1'b1;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    if (BCD_DIG > DIGITS) begin : g_ovf
      assign ovf[c] = |staging[c][BCD_W-1:DIGITS*4];
    end else begin : g_noOvf
      assign ovf[c] = 1'b0;
    end
    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
      logic [3:0] nib;
      if (d < BCD_DIG) begin : g_nib
        assign nib = staging[c][d*4 +: 4];
      end else begin : g_pad
        assign nib = 4'd0;
      end
      seg_digit_encoder u_enc (
        .digit (nib),
        .seg   (segRaw[c*DIGITS + d])
      );
    end
  end

  // Walk digits from the most significant down; blanking stops at the first
  // nonzero digit and never reaches the ones digit.
  always_comb begin
    hexNxt   = '1;
    leadZero = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      leadZero = 1'b1;
      for (int d = DIGITS - 1; d >= 0; d--) begin
        leadZero = leadZero && (segRaw[c*DIGITS + d] == SEG_0);
        if (ovf[c])
          hexNxt[(c*DIGITS + d)*7 +: 7] = SEG_DASH;
        else if (blankReg && leadZero && (d != 0))
          hexNxt[(c*DIGITS + d)*7 +: 7] = SEG_BLANK;
        else
          hexNxt[(c*DIGITS + d)*7 +: 7] = segRaw[c*DIGITS + d];
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      HexOut  <= '1;
      UpdDone <= 1'b0;
    end else begin
      UpdDone <= doCommit;
      if (doCommit) HexOut <= hexNxt;
    end
  end

endmodule

// File: tb/tb_multi_channel_seg_driver.sv
// Directed bench for multi_channel_seg_driver: default 2x8-bit instance plus
// a 4-channel, 10-bit, 3-digit instance.
module tb_multi_channel_seg_driver;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SB = 7'h7F,      SD = 7'b0111111;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [15:0] BinIn;
  logic        ModeSel, BlankEn, InValid, InReady, UpdDone;
  logic [27:0] HexOut;

  logic [39:0] BinIn1;
  logic        InValid1, InReady1, UpdDone1;
  logic [83:0] HexOut1;

  int nTests = 0;
  int nFail  = 0;

  always #5 Clk = ~Clk;

  multi_channel_seg_driver dut (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .BinIn   (BinIn),
    .ModeSel (ModeSel),
    .BlankEn (BlankEn),
    .InValid (InValid),
    .InReady (InReady),
    .HexOut  (HexOut),
    .UpdDone (UpdDone)
  );

  multi_channel_seg_driver #(.NUM_CH(4), .BIN_W(10), .DIGITS(3)) dutWide (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .BinIn   (BinIn1),
    .ModeSel (ModeSel),
    .BlankEn (BlankEn),
    .InValid (InValid1),
    .InReady (InReady1),
    .HexOut  (HexOut1),
    .UpdDone (UpdDone1)
  );

  task automatic checkVal(input string tag, input logic [127:0] got,
                          input logic [127:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic runTx(input string tag, input logic [15:0] bin,
                       input logic mode, input logic blank, output int lat);
    @(negedge Clk);
    BinIn   = bin;
    ModeSel = mode;
    BlankEn = blank;
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    checkVal({tag, "_acc"}, InReady, 1'b0);
    lat = 0;
    while (!UpdDone && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int pulses;

    Rst_n    = 1'b0;
    BinIn    = '0;
    ModeSel  = 1'b0;
    BlankEn  = 1'b0;
    InValid  = 1'b0;
    BinIn1   = '0;
    InValid1 = 1'b0;

    repeat (2) @(posedge Clk);
    #1;
    checkVal("rst_hex",   HexOut,  28'hFFFFFFF);
    checkVal("rst_ready", InReady, 1'b1);
    checkVal("rst_upd",   UpdDone, 1'b0);
    checkVal("rst_hexW",  HexOut1, {84{1'b1}});
    @(negedge Clk);
    Rst_n = 1'b1;

    // {42,7} direct
    runTx("v1", {8'd42, 8'd7}, 1'b0, 1'b0, lat);
    checkVal("v1_lat",   lat,     17);
    checkVal("v1_hex",   HexOut,  {S4, S2, S0, S7});
    checkVal("v1_ready", InReady, 1'b1);
    @(posedge Clk); #1;
    checkVal("v1_pulse", UpdDone, 1'b0);
    repeat (3) @(posedge Clk);
    #1;
    checkVal("v1_hold",  HexOut,  {S4, S2, S0, S7});

    // reversal
    runTx("v2", {8'd99, 8'd0}, 1'b1, 1'b0, lat);
    checkVal("v2_lat", lat,    17);
    checkVal("v2_hex", HexOut, {S0, S0, S9, S9});
    runTx("v3", {8'd150, 8'd1}, 1'b1, 1'b0, lat);
    checkVal("v3_hex", HexOut, {S0, S0, S9, S8});

    // blanking and overflow
    runTx("v4", {8'd5, 8'd255}, 1'b0, 1'b1, lat);
    checkVal("v4_hex", HexOut, {SB, S5, SD, SD});
    runTx("v5", {8'd0, 8'd10}, 1'b0, 1'b1, lat);
    checkVal("v5_hex", HexOut, {SB, S0, S1, S0});

    // InValid while busy is dropped
    @(negedge Clk);
    BinIn   = {8'd11, 8'd22};
    ModeSel = 1'b0;
    BlankEn = 1'b0;
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    checkVal("busy_acc", InReady, 1'b0);
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    checkVal("busy_ready", InReady, 1'b0);
    BinIn   = {8'd33, 8'd44};
    InValid = 1'b1;
    @(negedge Clk);
    InValid = 1'b0;
    lat = 5;
    while (!UpdDone && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    checkVal("busy_lat", lat,    17);
    checkVal("busy_hex", HexOut, {S1, S1, S2, S2});

    // back-to-back with InValid held; data changed after first accept
    @(negedge Clk);
    BinIn   = {8'd12, 8'd34};
    InValid = 1'b1;
    @(posedge Clk); #1;
    BinIn = {8'd56, 8'd78};
    checkVal("b2b_acc", InReady, 1'b0);
    lat = 0;
    while (!UpdDone && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    checkVal("b2b_lat1",  lat,     17);
    checkVal("b2b_hex1",  HexOut,  {S1, S2, S3, S4});
    checkVal("b2b_ready", InReady, 1'b1);
    @(posedge Clk); #1;
    checkVal("b2b_acc2",  InReady, 1'b0);
    checkVal("b2b_pulse", UpdDone, 1'b0);
    InValid = 1'b0;
    lat = 0;
    while (!UpdDone && lat < 100) begin
      @(posedge Clk); #1;
      lat++;
    end
    checkVal("b2b_lat2", lat,    17);
    checkVal("b2b_hex2", HexOut, {S5, S6, S7, S8});

    // reset during conversion
    @(negedge Clk);
    BinIn   = {8'd1, 8'd2};
    InValid = 1'b1;
    @(posedge Clk); #1;
    InValid = 1'b0;
    repeat (7) @(posedge Clk);
    @(negedge Clk);
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    checkVal("abort_hex",   HexOut,  28'hFFFFFFF);
    checkVal("abort_ready", InReady, 1'b1);
    checkVal("abort_upd",   UpdDone, 1'b0);
    @(negedge Clk);
    Rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(posedge Clk); #1;
      if (UpdDone) pulses++;
    end
    checkVal("abort_noupd", pulses, 0);
    checkVal("abort_hold",  HexOut, 28'hFFFFFFF);

    // wide instance: ch0=999, ch1=1000, ch2=7, ch3=0, blanking on
    @(negedge Clk);
    BinIn1   = {10'd0, 10'd7, 10'd1000, 10'd999};
    ModeSel  = 1'b0;
    BlankEn  = 1'b1;
    InValid1 = 1'b1;
    @(posedge Clk); #1;
    InValid1 = 1'b0;
    checkVal("w_acc", InReady1, 1'b0);
    lat = 0;
    while (!UpdDone1 && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
    checkVal("w_lat", lat, 41);
    checkVal("w_hex", HexOut1, {SB, SB, S0, SB, SB, S7, SD, SD, SD, S9, S9, S9});

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/multi_channel_seg_driver.md
# multi_channel_seg_driver

Parametrised, registered successor to the two-channel seven-segment encoding path. It accepts a vector of NUM_CH binary channel values through a valid/ready handshake and applies optional count-down reversal per transaction. Conversion to BCD runs serially (shift-and-add-3, one bit per cycle, one channel at a time). All channel displays are committed atomically to registered active-low segment outputs, with leading-zero blanking and overflow dashes. It sits between the timer counters and the board HEX displays.

## Interface
- NUM_CH, 2: number of channels.
- BIN_W, 8: width of each channel's binary value.
- DIGITS, 2: displayed digits per channel.
- REV_MAX, 99: reversal ceiling (BIN_W bits wide); must be ≤ 2^BIN_W−1.
- Clk  in  1  single clock; all logic on rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- BinIn  in  NUM_CH*BIN_W  channel values; channel 0 occupies the LSBs.
- ModeSel  in  1  1 = count-down display (reverse), 0 = direct.
- BlankEn  in  1  1 = blank leading zeros.
- InValid  in  1  request to load BinIn/ModeSel/BlankEn.
- InReady  out  1  high when idle and able to accept.
- HexOut  out  NUM_CH*DIGITS*7  segment bus; 7-bit digit slice k = ch*DIGITS+d (d=0 is the ones digit); bit order {g,f,e,d,c,b,a}; active-low.
- UpdDone  out  1  one-cycle pulse on the cycle HexOut changes.

## Operation
- States: IDLE, CONV, COMMIT.
- IDLE: InReady=1. On InValid&&InReady:
  - capture BinIn, ModeSel and BlankEn;
  - apply reversal per channel at capture: ModeSel=1 → v' = REV_MAX−v if v ≤ REV_MAX, else 0; ModeSel=0 → v' = v;
  - go to CONV with ch=0, bit=0.
- CONV: internal BCD accumulator of BCD_DIG = (BIN_W*3)/10+1 nibbles.
  - Each cycle: every nibble ≥5 gets +3, then shift left one bit, taking the MSB of v'[ch].
  - After BIN_W cycles, store the channel's BCD into staging and clear the accumulator. Advance to the next channel; after the last channel go to COMMIT.
- COMMIT (one cycle): per channel, build DIGITS digit codes, register them into HexOut, pulse UpdDone, return to IDLE.
  - Overflow: any BCD nibble at index ≥ DIGITS nonzero → every digit of that channel = SEG_DASH (7'b0111111).
  - Blanking: when BlankEn, leading zero digits = SEG_BLANK (7'h7F). Digit 0 is never blanked. Blanking does not apply to an overflowed channel.
  - Otherwise digits use the active-low LUT: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- InValid outside IDLE is ignored, not queued. Inputs are sampled only on the accept edge.
- HexOut holds its value between commits.

## Timing
- Reset (Rst_n low at an edge): state=IDLE, InReady=1, UpdDone=0, HexOut all ones (all blank); staging and accumulator cleared.
- Reset mid-CONV/COMMIT aborts the conversion: no UpdDone, HexOut blanked.
- Accept at edge T → InReady=0 from T.
- At edge T+NUM_CH*BIN_W+1:
  - HexOut is updated and UpdDone=1 for exactly one cycle;
  - InReady=1 again.
- Default latency is 17 cycles.
- Back-to-back: InValid held high → next accept occurs one edge after the commit edge. Throughput is one update per NUM_CH*BIN_W+2 cycles.
- UpdDone never asserts without a HexOut write.

## Structure
- Package seg_pkg holds SEG_BLANK, SEG_DASH, the ten digit constants, the state enum and the BCD_DIG width function.
- Sub-module seg_digit_encoder (combinational 4-bit → 7-bit, active-low, codes ≥10 → SEG_BLANK). It is instantiated NUM_CH*DIGITS times in the COMMIT path.
- The datapath (reverser, serial double-dabble, staging) and the FSM live in the top module.

## Test plan
- Reset: Rst_n low 2 cycles → HexOut=28'hFFFFFFF, InReady=1, UpdDone=0.
- BinIn={42,7}, ModeSel=0, BlankEn=0 → 17 cycles later ch1 shows "42", ch0 shows "07", one UpdDone pulse; HexOut stable afterwards.
- ModeSel=1: BinIn={99,0} → ch1 "00", ch0 "99"; then BinIn={150,1} → ch1 "00" (saturated), ch0 "98".
- ModeSel=0, BlankEn=1, BinIn={5,255} → ch1 blank then "5" (digit1=7'h7F, digit0=7'b0010010), ch0 two dashes.
- Busy handling:
  - Accept {11,22}, then assert InValid with {33,44} at cycle 5 → ignored; display "11","22".
  - With InValid held, the next accept occurs after InReady returns.
  - Reset at cycle 8 of a conversion → HexOut blank, no UpdDone.
- NUM_CH=4, BIN_W=10, DIGITS=3: 999 → "999"; 1000 → dashes; 7 with BlankEn → blank, blank, "7"; latency 41 cycles.
